// File: rtl/count_arb_pkg.sv
// Shared types and sizing for the count arbiter and its counter datapath.
// Also holds the round-robin pick so that both requesters are served under contention.
package count_arb_pkg;

    localparam int COUNT_W = 4;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // last = index of the requester served most recently; under contention the other one wins
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic               last);
        logic [NUM_REQ-1:0] pick;
        pick = req;
        if (&req) begin
            pick = last ? 2'b01 : 2'b10;
        end
        return pick;
    endfunction

endpackage

// File: rtl/count_core.sv
// Counter datapath: WIDTH-bit register with synchronous clear (priority) and enable.
// Flags when the count equals the supplied terminal value; no backpressure.
module count_core
    import count_arb_pkg::*;
#(
    parameter int WIDTH = COUNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] q,
    output logic             hit
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + 1'b1;
        end
    end

    assign hit = (q == term);

endmodule

// File: rtl/count_arbiter.sv
// Round-robin arbiter granting the shared counter for len+1 ticks, then a one-cycle done pulse.
// Optional COUNT_ARB_ABORT_EN: the granted requester dropping req during COUNT aborts the run.
module count_arbiter
    import count_arb_pkg::*;
#(
    parameter int WIDTH = COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   len0,
    input  logic [WIDTH-1:0]   len1,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic [WIDTH-1:0]   q,
    output logic               busy
);

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [NUM_REQ-1:0] done_nxt;
    logic [WIDTH-1:0]   len_lat;
    logic [WIDTH-1:0]   len_lat_nxt;
    logic               last;
    logic               last_nxt;
    logic               grant;
    logic               abort;
    logic               hit;
    logic               cnt_clr;
    logic               cnt_en;

    assign pick  = rr_pick(req, last);
    assign grant = (state == IDLE) && (|req);

`ifdef COUNT_ARB_ABORT_EN
    assign abort = (state == COUNT) && ((req & gnt) == '0);
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|req) state_nxt = COUNT;
            COUNT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs plus counter control; q holds on abort
    always_comb begin
        gnt_nxt     = gnt;
        done_nxt    = '0;
        len_lat_nxt = len_lat;
        last_nxt    = last;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        unique case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (grant) begin
                    gnt_nxt     = pick;
                    cnt_clr     = 1'b1;
                    len_lat_nxt = pick[1] ? len1 : len0;
                    last_nxt    = pick[1];
                end
            end
            COUNT: begin
                if (abort) begin
                    gnt_nxt = '0;
                end else if (hit) begin
                    done_nxt = gnt;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE:    gnt_nxt = '0;
            default: gnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt     <= '0;
            done    <= '0;
            len_lat <= '0;
            last    <= 1'b1;
        end else begin
            gnt     <= gnt_nxt;
            done    <= done_nxt;
            len_lat <= len_lat_nxt;
            last    <= last_nxt;
        end
    end

    assign busy = (state != IDLE);

    count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .term (len_lat),
        .q    (q),
        .hit  (hit)
    );

endmodule

// File: tb/tb_count_arbiter.sv
// Bench for count_arbiter: per-cycle vector table plus a long len=15 run, scoreboarded.
module tb_count_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [3:0] q;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] req;
        logic [3:0] l0;
        logic [3:0] l1;
        logic [1:0] gnt;
        logic [1:0] done;
        logic [3:0] q;
        logic       busy;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] gnt;
        logic [1:0] done;
        logic [3:0] q;
        logic       busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    count_arbiter #(.WIDTH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .len0 (len0),
        .len1 (len1),
        .gnt  (gnt),
        .done (done),
        .q    (q),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void t(input string name, input logic rst, input logic [1:0] rq,
                              input logic [3:0] l0, input logic [3:0] l1,
                              input logic [1:0] eg, input logic [1:0] ed,
                              input logic [3:0] eq, input logic eb);
        vec_t v;
        v.name = name; v.rst = rst; v.req = rq; v.l0 = l0; v.l1 = l1;
        v.gnt = eg; v.done = ed; v.q = eq; v.busy = eb;
        tbl.push_back(v);
    endfunction

    // Drive one cycle of inputs, queue the expectation, sample 1 time unit after the edge
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        reset = v.rst; req = v.req; len0 = v.l0; len1 = v.l1;
        e.name = v.name; e.gnt = v.gnt; e.done = v.done; e.q = v.q; e.busy = v.busy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        if (gnt !== got.gnt || done !== got.done || q !== got.q || busy !== got.busy) begin
            errors++;
            $display("FAIL %s: got gnt=%b done=%b q=%0d busy=%b, want gnt=%b done=%b q=%0d busy=%b",
                     got.name, gnt, done, q, busy, got.gnt, got.done, got.q, got.busy);
        end
    endtask

    task automatic run(input string name, input logic rst, input logic [1:0] rq,
                       input logic [3:0] l0, input logic [3:0] l1,
                       input logic [1:0] eg, input logic [1:0] ed,
                       input logic [3:0] eq, input logic eb);
        vec_t v;
        v.name = name; v.rst = rst; v.req = rq; v.l0 = l0; v.l1 = l1;
        v.gnt = eg; v.done = ed; v.q = eq; v.busy = eb;
        step(v);
    endtask

    initial begin
        reset = 1'b0; req = 2'b00; len0 = 4'd0; len1 = 4'd0;

        // reset for two edges, then idle
        t("rst0",   0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        t("rst1",   0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        t("idle0",  1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        t("idle1",  1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        // pointer after reset favours requester 0; len=0 runs
        t("ptr_g0", 1, 2'b11, 0, 0, 2'b01, 2'b00, 0, 1);
        t("ptr_d0", 1, 2'b11, 0, 0, 2'b01, 2'b01, 0, 1);
        t("ptr_i0", 1, 2'b10, 0, 0, 2'b00, 2'b00, 0, 0);
        t("ptr_g1", 1, 2'b10, 0, 0, 2'b10, 2'b00, 0, 1);
        t("len1_0", 1, 2'b10, 0, 0, 2'b10, 2'b10, 0, 1);
        t("ptr_i1", 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        // contention: len0=2, len1=5, both held
        t("c_g0",   1, 2'b11, 2, 5, 2'b01, 2'b00, 0, 1);
        t("c_q1",   1, 2'b11, 2, 5, 2'b01, 2'b00, 1, 1);
        t("c_q2",   1, 2'b11, 2, 5, 2'b01, 2'b00, 2, 1);
        t("c_d0",   1, 2'b11, 2, 5, 2'b01, 2'b01, 2, 1);
        t("c_gap",  1, 2'b11, 2, 5, 2'b00, 2'b00, 2, 0);
        t("c_g1",   1, 2'b11, 2, 5, 2'b10, 2'b00, 0, 1);
        for (int k = 1; k <= 5; k++) t("c_q1run", 1, 2'b11, 2, 5, 2'b10, 2'b00, 4'(k), 1);
        t("c_d1",   1, 2'b11, 2, 5, 2'b10, 2'b10, 5, 1);
        t("c_gap2", 1, 2'b11, 2, 5, 2'b00, 2'b00, 5, 0);
        t("c_g0b",  1, 2'b11, 2, 5, 2'b01, 2'b00, 0, 1);
        // len0 change after grant is ignored
        t("c_lchg1",1, 2'b01, 9, 5, 2'b01, 2'b00, 1, 1);
        t("c_lchg2",1, 2'b01, 9, 5, 2'b01, 2'b00, 2, 1);
        t("c_d0b",  1, 2'b01, 9, 5, 2'b01, 2'b01, 2, 1);
        t("c_end",  1, 2'b00, 9, 5, 2'b00, 2'b00, 2, 0);
        // single requester, len0=3
        t("s_g",    1, 2'b01, 3, 0, 2'b01, 2'b00, 0, 1);
        t("s_q1",   1, 2'b01, 3, 0, 2'b01, 2'b00, 1, 1);
        t("s_q2",   1, 2'b01, 3, 0, 2'b01, 2'b00, 2, 1);
        t("s_q3",   1, 2'b01, 3, 0, 2'b01, 2'b00, 3, 1);
        t("s_done", 1, 2'b01, 3, 0, 2'b01, 2'b01, 3, 1);
        t("s_gnt0", 1, 2'b00, 3, 0, 2'b00, 2'b00, 3, 0);
        t("s_hold", 1, 2'b00, 3, 0, 2'b00, 2'b00, 3, 0);
        // reset while q=2 in COUNT drops the run
        t("r_g",    1, 2'b01, 5, 0, 2'b01, 2'b00, 0, 1);
        t("r_q1",   1, 2'b01, 5, 0, 2'b01, 2'b00, 1, 1);
        t("r_q2",   1, 2'b01, 5, 0, 2'b01, 2'b00, 2, 1);
        t("r_rst",  0, 2'b01, 5, 0, 2'b00, 2'b00, 0, 0);
        t("r_nodn0",1, 2'b00, 5, 0, 2'b00, 2'b00, 0, 0);
        t("r_nodn1",1, 2'b00, 5, 0, 2'b00, 2'b00, 0, 0);
        // granted requester drops req at q=1
        t("a_g",    1, 2'b01, 4, 0, 2'b01, 2'b00, 0, 1);
        t("a_q1",   1, 2'b01, 4, 0, 2'b01, 2'b00, 1, 1);
`ifdef COUNT_ARB_ABORT_EN
        t("a_abort",1, 2'b00, 4, 0, 2'b00, 2'b00, 1, 0);
        t("a_nodn0",1, 2'b00, 4, 0, 2'b00, 2'b00, 1, 0);
        t("a_nodn1",1, 2'b00, 4, 0, 2'b00, 2'b00, 1, 0);
`else
        t("a_q2",   1, 2'b00, 4, 0, 2'b01, 2'b00, 2, 1);
        t("a_q3",   1, 2'b00, 4, 0, 2'b01, 2'b00, 3, 1);
        t("a_q4",   1, 2'b00, 4, 0, 2'b01, 2'b00, 4, 1);
        t("a_done", 1, 2'b00, 4, 0, 2'b01, 2'b01, 4, 1);
        t("a_end",  1, 2'b00, 4, 0, 2'b00, 2'b00, 4, 0);
`endif

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // len=15: count reaches 15 without wrapping, then done
        run("l15_g", 1, 2'b01, 15, 0, 2'b01, 2'b00, 0, 1);
        for (int k = 1; k <= 15; k++) run("l15_q", 1, 2'b01, 15, 0, 2'b01, 2'b00, 4'(k), 1);
        run("l15_done", 1, 2'b01, 15, 0, 2'b01, 2'b01, 15, 1);
        run("l15_end",  1, 2'b00, 15, 0, 2'b00, 2'b00, 15, 0);
        run("l15_hold", 1, 2'b00, 15, 0, 2'b00, 2'b00, 15, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_arbiter.md
# count_arbiter

Sequencing and arbitration controller for the shared 4-bit count resource. Two requesters each ask for a timed run of N+1 ticks. The block grants the counter to one requester at a time using round-robin, then clears and steps the count and signals completion with a one-cycle done pulse. It sits between the requesting control logic and the 4-bit counter datapath, and it owns that counter exclusively.

## Interface
Parameters:
- `WIDTH`, 4, counter width; `len0`/`len1`/`q` use this width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on rising `clk`.
- `req`  in  2  request per requester; level, held until its `done`.
- `len0`  in  WIDTH  terminal count for requester 0; latched at grant.
- `len1`  in  WIDTH  terminal count for requester 1; latched at grant.
- `gnt`  out  2  one-hot grant; at most one bit high.
- `done`  out  2  one-cycle completion pulse to the granted requester.
- `q`  out  WIDTH  current count value.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Reset (`reset`=0 at an edge):
  - state goes to IDLE.
  - `gnt`=00, `done`=00, `q`=0, `busy`=0.
  - Round-robin pointer gives priority to requester 0.
- The FSM has three states: IDLE, COUNT and DONE.
- **IDLE:**
  - With `req`≠00, grant one requester and go to COUNT.
  - The grant sets the matching `gnt` bit, clears `q` to 0 and latches `len_lat` from that requester's `len`.
  - If only one request is active, that requester wins.
  - If both are active, the requester that was not served last wins. The pointer updates at each grant.
  - With `req`=00, `q` holds its last value.
- **COUNT:**
  - If `q`==`len_lat`, go to DONE and set `done[g]`=1.
  - Otherwise `q` ← `q`+1, modulo 2^WIDTH (it cannot wrap, because `len_lat` ≤ 2^WIDTH−1).
- **DONE:**
  - Go to IDLE and clear `gnt` and `done`; `q` holds the final value (= `len_lat`).
- `len0`/`len1` changes after the grant are ignored for the current run.
- In COUNT/DONE, a `req` from the non-granted requester stays pending. It is arbitrated on the next IDLE edge.
- A requester that keeps `req` high after its `done` is a new request. Round-robin makes it lose to a pending other requester.
- `len`=0 is legal: COUNT lasts one cycle and `q` stays 0.

## Timing
- Request sampled in IDLE at edge E.
  - `gnt` and `q`=0 are visible after E.
  - `q` reaches `len_lat` after edge E+len.
  - `done` is high after E+len+1 for one cycle.
  - `gnt` falls after E+len+2.
- `gnt` is high for len+2 cycles. `done` overlaps the last `gnt` cycle.
- Earliest next grant is at edge E+len+3, so there is one IDLE cycle between runs.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `reset` low in any state overrides all other activity at that edge.
  - An in-flight run is dropped and no `done` is issued.

## Configuration
- `COUNT_ARB_ABORT_EN` defined:
  - In COUNT, if `req[g]` of the granted requester is 0 at an edge, go straight to IDLE, clear `gnt` and hold `q`.
  - No `done` pulse is issued.
  - The round-robin pointer still records that requester as last served.
- `COUNT_ARB_ABORT_EN` undefined:
  - `req` is not examined during COUNT/DONE.
  - A run always completes with its `done` pulse.

## Structure
- Shared package `count_arb_pkg`:
  - State enum `{IDLE, COUNT, DONE}`.
  - `COUNT_W` = 4 as the default for `WIDTH`.
  - `NUM_REQ` = 2.
- Sub-module `count_core`:
  - The counter datapath: WIDTH-bit register with synchronous clear and enable.
  - Uses the same `clk`/`reset` conventions.
  - `count_arbiter` drives its clear and enable from the FSM.

## Test plan
- Reset held for 2 edges, then released with `req`=00 → `gnt`=00, `done`=00, `q`=0, `busy`=0 on every cycle.
- Single requester: `req`=01, `len0`=3 at E → `q` goes 0,1,2,3; `done`=01 after E+4; `gnt`=00 after E+5.
- Contention: `req`=11 held, `len0`=2, `len1`=5 →
  - requester 0 is served first (`done[0]` after E+3);
  - then requester 1 is granted at E+5 (`done[1]` after E+11);
  - then requester 0 is granted again.
- Edge case: `len1`=0 → one COUNT cycle with `q`=0, then `done[1]`; `len`=15 → `q` reaches 15, never wraps, then `done`.
- Reset mid-run: `reset`=0 while `q`=2 in COUNT → next cycle IDLE, `q`=0, `gnt`=00, and no `done` pulse.
- With `COUNT_ARB_ABORT_EN`: granted `req` dropped at `q`=1 → IDLE next cycle, `q`=1 held, and no `done`. Without the macro, the same stimulus completes with a `done` pulse.
